// File: rtl/wcr_pkg.sv
// Shared definitions for the write/consume command register: status bit
// positions and the occupancy-counter width helper.
package wcr_pkg;

  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  // Counter must hold 0..depth inclusive, hence one bit more than the pointer.
  function automatic int unsigned cntWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/write_consume_register_if.sv
// Processor bus plus I/O valid/ready handshake of the write/consume register.
interface write_consume_register_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  Sys_WrEn;
  logic                  Sys_RdEn;
  logic                  Sys_DataSelect;
  logic                  Sys_StatusSelect;
  logic [DATA_WIDTH-1:0] Sys_WrData;
  logic [DATA_WIDTH-1:0] Sys_RdData;
  logic [DATA_WIDTH-1:0] IO_Data;
  logic                  IO_Valid;
  logic                  IO_Ready;

  modport master (
    output Sys_WrEn, Sys_RdEn, Sys_DataSelect, Sys_StatusSelect, Sys_WrData, IO_Ready,
    input  Sys_RdData, IO_Data, IO_Valid
  );

  modport slave (
    input  Sys_WrEn, Sys_RdEn, Sys_DataSelect, Sys_StatusSelect, Sys_WrData, IO_Ready,
    output Sys_RdData, IO_Data, IO_Valid
  );

endinterface

// File: rtl/wcr_fifo_core.sv
// Small power-of-two FIFO: storage, wrapping pointers and occupancy count.
module wcr_fifo_core
  import wcr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_WIDTH-1:0]       wrData,
  output logic [DATA_WIDTH-1:0]       headData_c,
  output logic [cntWidth(DEPTH)-1:0]  count,
  output logic                        full_c,
  output logic                        empty_c,
  output logic                        pushOk_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cntWidth(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  popOk;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign popOk      = pop & ~empty_c;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign pushOk_c   = push & (~full_c | popOk);
  assign headData_c = mem[rdPtr];

  // Storage is deliberately not reset; only accepted pushes outside reset write it.
  always_ff @(posedge clk) begin
    if (rstN && pushOk_c) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk_c) wrPtr <= wrPtr + PTR_W'(1);
      if (popOk)    rdPtr <= rdPtr + PTR_W'(1);
      case ({pushOk_c, popOk})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/write_consume_register.sv
// Processor-to-I/O command register with status word and sticky overflow.
// Optional drain interrupt output Irq enabled by defining WCR_DRAIN_IRQ_EN.
module write_consume_register
  import wcr_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  write_consume_register_if.slave  bus
`ifdef WCR_DRAIN_IRQ_EN
  ,
  output logic                     Irq
`endif
);

  localparam int unsigned CNT_W = cntWidth(DEPTH);

  logic [DATA_WIDTH-1:0] headData_c;
  logic [CNT_W-1:0]      count;
  logic                  full_c;
  logic                  empty_c;
  logic                  pushOk_c;
  logic                  push;
  logic                  pop;
  logic                  valid_c;
  logic                  statusRd;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] status_c;

  assign push     = bus.Sys_WrEn & bus.Sys_DataSelect;
  assign valid_c  = (count != '0);
  assign pop      = valid_c & bus.IO_Ready;
  assign statusRd = bus.Sys_RdEn & bus.Sys_StatusSelect;

  wcr_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk        (Clock),
    .rstN       (Reset),
    .push       (push),
    .pop        (pop),
    .wrData     (bus.Sys_WrData),
    .headData_c (headData_c),
    .count      (count),
    .full_c     (full_c),
    .empty_c    (empty_c),
    .pushOk_c   (pushOk_c)
  );

  assign bus.IO_Valid = valid_c;
  assign bus.IO_Data  = valid_c ? headData_c : RESET_DATA;

  always_comb begin
    status_c                          = '0;
    status_c[STAT_EMPTY]              = empty_c;
    status_c[STAT_FULL]               = full_c;
    status_c[STAT_OVF]                = overflow;
    status_c[STAT_CNT_LSB +: CNT_W]   = count;
  end

  // Status select has priority; a data-select read is a non-popping peek.
  always_comb begin
    bus.Sys_RdData = '0;
    if (bus.Sys_StatusSelect)    bus.Sys_RdData = status_c;
    else if (bus.Sys_DataSelect) bus.Sys_RdData = bus.IO_Data;
  end

  // Sticky overflow: a dropped push outranks the clear-on-read.
  always_ff @(posedge Clock) begin
    if (!Reset)                  overflow <= 1'b0;
    else if (push && !pushOk_c)  overflow <= 1'b1;
    else if (statusRd)           overflow <= 1'b0;
  end

`ifdef WCR_DRAIN_IRQ_EN
  // One-cycle pulse after the last entry drains with no refill that cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) Irq <= 1'b0;
    else        Irq <= pop & (count == CNT_W'(1)) & ~push;
  end
`endif

endmodule

// File: tb/tb_write_consume_register.sv
// Directed self-checking bench for write_consume_register (DEPTH=2).
module tb_write_consume_register;

  localparam int unsigned DW = 32;

  logic Clock;
  logic Reset;
`ifdef WCR_DRAIN_IRQ_EN
  logic Irq;
`endif

  int nAsserts = 0;
  int nFail    = 0;

  write_consume_register_if #(.DATA_WIDTH(DW)) bus ();

  write_consume_register #(
    .DATA_WIDTH (DW),
    .DEPTH      (2),
    .RESET_DATA ('0)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
`ifdef WCR_DRAIN_IRQ_EN
    ,
    .Irq   (Irq)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    bus.Sys_WrEn         = 1'b0;
    bus.Sys_RdEn         = 1'b0;
    bus.Sys_DataSelect   = 1'b0;
    bus.Sys_StatusSelect = 1'b0;
    bus.Sys_WrData       = '0;
    bus.IO_Ready         = 1'b0;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkIrq(input string tag, input logic exp);
`ifdef WCR_DRAIN_IRQ_EN
    check(tag, DW'(Irq), DW'(exp));
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  // Combinational status peek; when clr is set the following edge clears Overflow.
  task automatic statusPeek(input string tag, input logic clr, input logic [DW-1:0] exp);
    bus.Sys_StatusSelect = 1'b1;
    bus.Sys_RdEn         = clr;
    #1;
    check(tag, bus.Sys_RdData, exp);
  endtask

  task automatic write(input logic [DW-1:0] d);
    bus.Sys_WrEn       = 1'b1;
    bus.Sys_DataSelect = 1'b1;
    bus.Sys_WrData     = d;
    tick();
    idle();
  endtask

  task automatic popOne();
    bus.IO_Ready = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    Reset = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    #1;
    check("rst_valid", DW'(bus.IO_Valid), 32'h0);
    check("rst_data", bus.IO_Data, 32'h0);
    statusPeek("rst_status", 1'b1, 32'h0000_0001);
    checkIrq("rst_irq", 1'b0);
    tick();
    idle();

    // Single entry, latency, stability, peek, drain pulse
    write(32'hA5A5_0001);
    check("wr1_valid", DW'(bus.IO_Valid), 32'h1);
    check("wr1_data", bus.IO_Data, 32'hA5A5_0001);
    statusPeek("wr1_status", 1'b0, 32'h0000_0100);
    idle();
    bus.Sys_DataSelect = 1'b1;
    bus.Sys_RdEn       = 1'b1;
    #1;
    check("wr1_peek", bus.Sys_RdData, 32'hA5A5_0001);
    tick();
    idle();
    check("wr1_stable", bus.IO_Data, 32'hA5A5_0001);
    check("wr1_peek_nopop", DW'(bus.IO_Valid), 32'h1);
    popOne();
    check("wr1_drained", DW'(bus.IO_Valid), 32'h0);
    check("wr1_data_rst", bus.IO_Data, 32'h0);
    checkIrq("wr1_irq_pulse", 1'b1);
    tick();
    checkIrq("wr1_irq_off", 1'b0);

    // Write to status select only is ignored
    bus.Sys_WrEn         = 1'b1;
    bus.Sys_StatusSelect = 1'b1;
    bus.Sys_WrData       = 32'hDEAD_BEEF;
    tick();
    idle();
    check("stat_wr_ignored", DW'(bus.IO_Valid), 32'h0);

    // Overflow on third write
    write(32'h11);
    write(32'h22);
    write(32'h33);
    statusPeek("ovf_status", 1'b1, 32'h0000_0206);
    tick();
    idle();
    check("ovf_head0", bus.IO_Data, 32'h11);
    popOne();
    check("ovf_head1", bus.IO_Data, 32'h22);
    popOne();
    check("ovf_empty", DW'(bus.IO_Valid), 32'h0);
    checkIrq("ovf_irq", 1'b1);
    statusPeek("ovf_cleared", 1'b1, 32'h0000_0001);
    tick();
    idle();

    // Full buffer: push and pop in the same cycle
    write(32'h11);
    write(32'h22);
    bus.Sys_WrEn       = 1'b1;
    bus.Sys_DataSelect = 1'b1;
    bus.Sys_WrData     = 32'h44;
    bus.IO_Ready       = 1'b1;
    tick();
    idle();
    statusPeek("pp_status", 1'b0, 32'h0000_0202);
    idle();
    check("pp_head0", bus.IO_Data, 32'h22);
    popOne();
    check("pp_head1", bus.IO_Data, 32'h44);
    popOne();
    check("pp_empty", DW'(bus.IO_Valid), 32'h0);

    // Status read coincident with a dropped push: set wins
    write(32'h66);
    write(32'h77);
    bus.Sys_WrEn       = 1'b1;
    bus.Sys_DataSelect = 1'b1;
    bus.Sys_WrData     = 32'h88;
    statusPeek("race_rd0", 1'b1, 32'h0000_0202);
    tick();
    idle();
    statusPeek("race_rd1", 1'b1, 32'h0000_0206);
    tick();
    idle();
    check("race_head", bus.IO_Data, 32'h66);

    // Reset mid-operation with a concurrent push
    Reset              = 1'b0;
    bus.Sys_WrEn       = 1'b1;
    bus.Sys_DataSelect = 1'b1;
    bus.Sys_WrData     = 32'h55;
    tick();
    Reset = 1'b1;
    idle();
    check("mid_rst_valid", DW'(bus.IO_Valid), 32'h0);
    check("mid_rst_data", bus.IO_Data, 32'h0);
    statusPeek("mid_rst_status", 1'b0, 32'h0000_0001);
    idle();
    write(32'h99);
    check("mid_rst_no55", bus.IO_Data, 32'h99);
    statusPeek("mid_rst_cnt1", 1'b0, 32'h0000_0100);
    idle();
    popOne();
    check("final_empty", DW'(bus.IO_Valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
